// File: rtl/eth_csum_pkg.sv
// Shared word layout, checksum-queue entry and output FSM encoding for eth_csum_insert.
package eth_csum_pkg;
  localparam int WORD_W    = 73;
  localparam int DATA_W    = 64;
  localparam int KEEP_W    = 8;
  localparam int KEEP_LSB  = 64;
  localparam int TLAST_BIT = 72;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } word_t;

  typedef struct packed {
    logic        en;
    logic [15:0] ofs;
    logic [15:0] sum;
  } sum_ent_t;

  localparam int SUM_W = $bits(sum_ent_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_XFER = 2'd2
  } state_t;
endpackage

// File: rtl/eth_sync_fifo.sv
// Single-clock FIFO with registered read data; a write into a full FIFO is accepted
// only when a read frees a slot in the same cycle, otherwise it is dropped and flagged.
module eth_sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count,
  output logic          drop
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         empty;
  logic         full;
  logic         rd_ok;
  logic         wr_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  assign drop  = wr_en && !wr_ok;
  assign count = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/eth_csum_insert.sv
// Buffers frames and their checksum entries, then replays each frame on AXI-stream
// with TxSum patched at byte CsInsert; first beat 2 cycles after both queues hold data.
module eth_csum_insert import eth_csum_pkg::*; #(
  parameter int C_ADDR_W = 9,
  parameter int C_SUMQ_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_fifo_wren,
  input  logic [WORD_W-1:0] data_fifo_wdata,
  output logic              data_fifo_afull,
  input  logic              Sum_valid,
  input  logic [15:0]       TxSum,
  input  logic [15:0]       CsInsert,
  input  logic              CsEn,
  output logic [63:0]       m_tdata,
  output logic [7:0]        m_tkeep,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              ovf_err
);
  localparam logic [C_ADDR_W:0] BUF_DEPTH = (C_ADDR_W+1)'(2**C_ADDR_W);

  word_t             buf_word;
  sum_ent_t          sum_ent;
  logic [C_ADDR_W:0] buf_count;
  logic [C_SUMQ_W:0] sum_count;
  logic              buf_drop, sum_drop;
  logic              buf_rd, sum_rd;
  logic              buf_empty, sum_empty;
  logic              start_ok, beat, vld;
  logic [15:0]       byte_cnt;
  state_t            state, state_nxt;

  // The checksum queue's read register doubles as the per-frame entry latch.
  eth_sync_fifo #(.W(WORD_W), .AW(C_ADDR_W)) u_frame_buf (
    .clk(clk), .resetn(resetn),
    .wr_en(data_fifo_wren), .wr_data(data_fifo_wdata),
    .rd_en(buf_rd), .rd_data(buf_word),
    .count(buf_count), .drop(buf_drop)
  );

  eth_sync_fifo #(.W(SUM_W), .AW(C_SUMQ_W)) u_sum_q (
    .clk(clk), .resetn(resetn),
    .wr_en(Sum_valid), .wr_data({CsEn, CsInsert, TxSum}),
    .rd_en(sum_rd), .rd_data(sum_ent),
    .count(sum_count), .drop(sum_drop)
  );

  assign buf_empty       = (buf_count == '0);
  assign sum_empty       = (sum_count == '0);
  assign start_ok        = !buf_empty && !sum_empty;
  assign beat            = vld && m_tready;
  assign data_fifo_afull = (BUF_DEPTH - buf_count) < (C_ADDR_W+1)'(4);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_XFER;
      ST_XFER: if (beat && buf_word.last) state_nxt = start_ok ? ST_LOAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Never fetch past the word carrying tlast; the next frame starts from LOAD.
  always_comb begin
    buf_rd = 1'b0;
    sum_rd = 1'b0;
    case (state)
      ST_LOAD: begin
        buf_rd = 1'b1;
        sum_rd = 1'b1;
      end
      ST_XFER: buf_rd = !buf_empty && (!vld || (m_tready && !buf_word.last));
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld      <= 1'b0;
      byte_cnt <= '0;
      ovf_err  <= 1'b0;
    end else begin
      if (buf_rd)        vld <= 1'b1;
      else if (m_tready) vld <= 1'b0;
      if (state == ST_LOAD) byte_cnt <= '0;
      else if (beat)        byte_cnt <= byte_cnt + 16'd8;
      if (buf_drop || sum_drop) ovf_err <= 1'b1;
    end
  end

  always_comb begin
    m_tdata = buf_word.data;
    for (int i = 0; i < 8; i++) begin
      if (sum_ent.en && buf_word.keep[i]) begin
        if ((byte_cnt + 16'(i)) == sum_ent.ofs)
          m_tdata[8*i +: 8] = sum_ent.sum[15:8];
        else if ((byte_cnt + 16'(i)) == (sum_ent.ofs + 16'd1))
          m_tdata[8*i +: 8] = sum_ent.sum[7:0];
      end
    end
  end

  assign m_tkeep  = buf_word.keep;
  assign m_tlast  = buf_word.last;
  assign m_tvalid = vld;
endmodule

// File: tb/tb_eth_csum_insert.sv
// Directed bench for eth_csum_insert: expected frames built from a byte pattern and patched by hand.
module tb_eth_csum_insert;
  localparam int AW    = 9;
  localparam int SW    = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_fifo_wren = 1'b0;
  logic [72:0] data_fifo_wdata = '0;
  logic        data_fifo_afull;
  logic        Sum_valid = 1'b0;
  logic [15:0] TxSum = '0;
  logic [15:0] CsInsert = '0;
  logic        CsEn = 1'b0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        ovf_err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_b [0:127];
  logic [63:0] rx_dat [0:15];

  eth_csum_insert #(.C_ADDR_W(AW), .C_SUMQ_W(SW)) dut (
    .clk(clk), .resetn(resetn),
    .data_fifo_wren(data_fifo_wren), .data_fifo_wdata(data_fifo_wdata),
    .data_fifo_afull(data_fifo_afull),
    .Sum_valid(Sum_valid), .TxSum(TxSum), .CsInsert(CsInsert), .CsEn(CsEn),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int seed, input int b);
    return 8'(seed * 37 + b * 5 + 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    tick; tick;
    resetn = 1'b1;
    tick;
  endtask

  task automatic write_frame(input int seed, input int nbytes);
    int          nb;
    logic [63:0] d;
    logic [7:0]  k;
    nb = (nbytes + 7) / 8;
    for (int w = 0; w < nb; w++) begin
      d = '0;
      k = '0;
      for (int l = 0; l < 8; l++) begin
        if (8 * w + l < nbytes) begin
          d[8*l +: 8] = pat(seed, 8 * w + l);
          k[l] = 1'b1;
        end
      end
      data_fifo_wdata = {(w == nb - 1), k, d};
      data_fifo_wren  = 1'b1;
      tick;
    end
    data_fifo_wren = 1'b0;
  endtask

  task automatic push_sum(input logic en, input logic [15:0] ins, input logic [15:0] sum);
    Sum_valid = 1'b1;
    CsEn      = en;
    CsInsert  = ins;
    TxSum     = sum;
    tick;
    Sum_valid = 1'b0;
  endtask

  task automatic build_exp(input int seed, input int nbytes, input logic en,
                           input int ins, input logic [15:0] sum);
    for (int b = 0; b < 128; b++) exp_b[b] = (b < nbytes) ? pat(seed, b) : 8'h00;
    if (en) begin
      if (ins < nbytes)     exp_b[ins]     = sum[15:8];
      if (ins + 1 < nbytes) exp_b[ins + 1] = sum[7:0];
    end
  endtask

  task automatic recv_frame(input string nm, input int nbytes, input bit rnd, output int span);
    int          nb, beat, first, cyc, lanes;
    logic [63:0] ed;
    logic [7:0]  ek;
    nb = (nbytes + 7) / 8;
    beat = 0; first = 0; cyc = 0; span = -1;
    while (beat < nb && cyc < 400) begin
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_tvalid && m_tready) begin
        lanes = (nbytes - 8 * beat > 8) ? 8 : nbytes - 8 * beat;
        ed = '0;
        ek = '0;
        for (int l = 0; l < 8; l++) begin
          if (l < lanes) begin
            ed[8*l +: 8] = exp_b[8 * beat + l];
            ek[l] = 1'b1;
          end
        end
        chk($sformatf("%s b%0d data", nm, beat), m_tdata, ed);
        chk($sformatf("%s b%0d keep", nm, beat), 64'(m_tkeep), 64'(ek));
        chk($sformatf("%s b%0d last", nm, beat), 64'(m_tlast), 64'(beat == nb - 1));
        rx_dat[beat] = m_tdata;
        if (beat == 0) first = cyc;
        if (beat == nb - 1) span = cyc - first;
        beat++;
      end
      tick;
      cyc++;
    end
    if (beat < nb) chk({nm, " timeout beats"}, 64'(beat), 64'(nb));
  endtask

  initial begin
    int lat, span, seen, done, cyc;

    // Reset values
    tick; tick;
    chk("rst tvalid", 64'(m_tvalid), 64'd0);
    chk("rst tlast", 64'(m_tlast), 64'd0);
    chk("rst tdata", m_tdata, 64'd0);
    chk("rst tkeep", 64'(m_tkeep), 64'd0);
    chk("rst ovf", 64'(ovf_err), 64'd0);
    chk("rst afull", 64'(data_fifo_afull), 64'd0);
    resetn = 1'b1;
    tick;

    // 60-byte frame, checksum at 40
    write_frame(1, 60);
    push_sum(1'b1, 16'd40, 16'hBEEF);
    lat = 0;
    while (!m_tvalid && lat < 20) begin
      tick;
      lat++;
    end
    chk("t1 latency", 64'(lat), 64'd2);
    build_exp(1, 60, 1'b1, 40, 16'hBEEF);
    recv_frame("t1", 60, 1'b0, span);
    chk("t1 no gaps", 64'(span), 64'd7);
    chk("t1 beat5 lanes01", 64'(rx_dat[5][15:0]), 64'h0000_0000_0000_EFBE);

    // Checksum straddling a beat boundary
    write_frame(2, 60);
    push_sum(1'b1, 16'd39, 16'h1234);
    build_exp(2, 60, 1'b1, 39, 16'h1234);
    recv_frame("t2", 60, 1'b0, span);
    chk("t2 beat4 lane7", 64'(rx_dat[4][63:56]), 64'h12);
    chk("t2 beat5 lane0", 64'(rx_dat[5][7:0]), 64'h34);

    // Second checksum byte falls past the last kept lane
    write_frame(9, 60);
    push_sum(1'b1, 16'd59, 16'hA55A);
    build_exp(9, 60, 1'b1, 59, 16'hA55A);
    recv_frame("t2b", 60, 1'b0, span);
    chk("t2b beat7 lanes34", 64'(rx_dat[7][39:24]), 64'h00A5);

    // Three queued frames, random backpressure
    write_frame(3, 60);
    write_frame(4, 64);
    write_frame(5, 45);
    push_sum(1'b0, 16'd20, 16'hFFFF);
    push_sum(1'b1, 16'd10, 16'hC0DE);
    push_sum(1'b0, 16'd3, 16'h5555);
    build_exp(3, 60, 1'b0, 20, 16'hFFFF);
    recv_frame("t3f1", 60, 1'b1, span);
    build_exp(4, 64, 1'b1, 10, 16'hC0DE);
    recv_frame("t3f2", 64, 1'b1, span);
    chk("t3f2 beat1 lanes23", 64'(rx_dat[1][31:16]), 64'hDEC0);
    build_exp(5, 45, 1'b0, 3, 16'h5555);
    recv_frame("t3f3", 45, 1'b1, span);

    // Frame buffer fill and overflow
    do_reset;
    m_tready = 1'b0;
    data_fifo_wdata = {1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF};
    data_fifo_wren  = 1'b1;
    for (int i = 0; i < DEPTH - 4; i++) tick;
    data_fifo_wren = 1'b0;
    chk("t4 afull at 4 free", 64'(data_fifo_afull), 64'd0);
    data_fifo_wren = 1'b1;
    tick;
    data_fifo_wren = 1'b0;
    chk("t4 afull at 3 free", 64'(data_fifo_afull), 64'd1);
    data_fifo_wren = 1'b1;
    tick; tick; tick;
    data_fifo_wren = 1'b0;
    chk("t4 ovf when just full", 64'(ovf_err), 64'd0);
    data_fifo_wren = 1'b1;
    tick;
    data_fifo_wren = 1'b0;
    chk("t4 ovf after extra write", 64'(ovf_err), 64'd1);
    chk("t4 no output", 64'(m_tvalid), 64'd0);

    // Checksum queue overflow
    do_reset;
    chk("t4 ovf cleared", 64'(ovf_err), 64'd0);
    chk("t4 afull cleared", 64'(data_fifo_afull), 64'd0);
    for (int i = 0; i < (1 << SW); i++) push_sum(1'b1, 16'(i), 16'h0);
    chk("t4 sumq full no ovf", 64'(ovf_err), 64'd0);
    push_sum(1'b1, 16'd0, 16'h0);
    chk("t4 sumq ovf", 64'(ovf_err), 64'd1);

    // Reset during beat 3
    do_reset;
    write_frame(6, 60);
    push_sum(1'b1, 16'd40, 16'h7777);
    m_tready = 1'b1;
    done = 0;
    cyc = 0;
    while (cyc < 100 && !(m_tvalid && done == 3)) begin
      if (m_tvalid) done++;
      tick;
      cyc++;
    end
    chk("t5 reached beat3", 64'(done), 64'd3);
    resetn = 1'b0;
    #1;
    chk("t5 rst tvalid", 64'(m_tvalid), 64'd0);
    chk("t5 rst tdata", m_tdata, 64'd0);
    chk("t5 rst tkeep", 64'(m_tkeep), 64'd0);
    chk("t5 rst tlast", 64'(m_tlast), 64'd0);
    tick; tick;
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (m_tvalid) seen = 1;
      tick;
    end
    chk("t5 quiet after release", 64'(seen), 64'd0);
    write_frame(7, 60);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_tvalid) seen = 1;
      tick;
    end
    chk("t5 quiet without sum", 64'(seen), 64'd0);
    push_sum(1'b1, 16'd12, 16'h1111);
    build_exp(7, 60, 1'b1, 12, 16'h1111);
    recv_frame("t5", 60, 1'b0, span);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
